// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: measures incoming VGA sync timing, locks to it and emits pixel coordinates.
// Define VGA_SYNC_DEC_WATCHDOG_EN to add a stuck-hsync watchdog.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_meas,
    output logic [9:0]  v_meas,
    output logic        sync_err
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [10:0] H_EXP  = 11'(H_TOTAL);
    localparam logic [9:0]  V_EXP  = 10'(V_TOTAL);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    logic        hs1, vs1, bl1;
    logic        hs1_d, vs1_d, bl1_d;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [1:0]  state, state_nx;
    logic [3:0]  good_cnt, good_nx;
    logic        vs_pend;
    logic        err_nx, fs_nx;

    logic        hs_edge, vs_edge, act_start;
    logic [10:0] h_inc, h_meas_nx;
    logic [9:0]  v_inc, v_cnt_nx;
    logic        match;

    assign hs_edge   = hs1_d & ~hs1;
    assign vs_edge   = vs1_d & ~vs1;
    assign act_start = bl1_d & ~bl1;

    assign h_inc     = (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
    assign h_meas_nx = hs_edge ? h_inc : h_meas;
    assign v_inc     = (v_cnt == 10'h3FF) ? v_cnt : v_cnt + 10'd1;
    // A coincident hsync edge belongs to the frame that is closing.
    assign v_cnt_nx  = hs_edge ? v_inc : v_cnt;
    assign match     = (h_meas_nx == H_EXP) && (v_cnt_nx == V_EXP);

    assign locked    = (state == LOCKED);

`ifdef VGA_SYNC_DEC_WATCHDOG_EN
    localparam logic [11:0] WD_LIM = 12'(2 * H_TOTAL);

    logic [11:0] wd_cnt;
    logic        wd_trip;

    assign wd_trip = (state != SEARCH) && !hs_edge &&
                     (wd_cnt == WD_LIM - 12'd1);

    always_ff @(posedge clk25) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (hs_edge || wd_trip) begin
            wd_cnt <= '0;
        end else if (wd_cnt != 12'hFFF) begin
            wd_cnt <= wd_cnt + 12'd1;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_nx   = 1'b0;
        fs_nx    = 1'b0;
        if (vs_edge) begin
            unique case (state)
                SEARCH: begin
                    state_nx = ALIGN;
                    good_nx  = '0;
                end
                ALIGN: begin
                    if (match) begin
                        good_nx = good_cnt + 4'd1;
                        if (good_nx == LOCK_N) state_nx = LOCKED;
                    end else begin
                        state_nx = SEARCH;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        fs_nx = 1'b1;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = SEARCH;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
`ifdef VGA_SYNC_DEC_WATCHDOG_EN
        if (wd_trip) begin
            state_nx = SEARCH;
            err_nx   = (state == LOCKED);
            fs_nx    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            hs1_d       <= 1'b1;
            vs1_d       <= 1'b1;
            bl1         <= 1'b0;
            bl1_d       <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_meas      <= '0;
            v_meas      <= '0;
            state       <= SEARCH;
            good_cnt    <= '0;
            vs_pend     <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_valid    <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            hs1   <= hsync;
            vs1   <= vsync;
            bl1   <= blank;
            hs1_d <= hs1;
            vs1_d <= vs1;
            bl1_d <= bl1;

            h_cnt  <= hs_edge ? 11'd0 : h_inc;
            h_meas <= h_meas_nx;
            if (vs_edge) begin
                v_meas <= v_cnt_nx;
                v_cnt  <= '0;
            end else begin
                v_cnt  <= v_cnt_nx;
            end

            state       <= state_nx;
            good_cnt    <= good_nx;
            sync_err    <= err_nx;
            frame_start <= fs_nx;
            px_valid    <= locked & ~bl1;

            if (act_start) begin
                px_x <= '0;
            end else if (!bl1 && px_x != 10'h3FF) begin
                px_x <= px_x + 10'd1;
            end

            // First active line after a vsync edge restarts the row count.
            if (act_start) begin
                if (vs_pend || vs_edge) begin
                    px_y <= '0;
                end else if (px_y != 10'h3FF) begin
                    px_y <= px_y + 10'd1;
                end
            end
            vs_pend <= act_start ? 1'b0 : (vs_edge ? 1'b1 : vs_pend);
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of lock, coordinates, loss of sync and reset.
// Uses a scaled 40x12 raster (24x8 active) so every frame is only 480 clocks.
module tb_vga_sync_decoder;

    localparam int H       = 40;
    localparam int V       = 12;
    localparam int H_ACT   = 24;
    localparam int V_ACT   = 8;
    localparam int HS_BEG  = 28;
    localparam int HS_END  = 34;
    localparam int VS_LINE = 9;
    localparam int LONG_V  = 7;

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        blank = 1'b1;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic        px_valid;
    logic        frame_start;
    logic        locked;
    logic [10:0] h_meas;
    logic [9:0]  v_meas;
    logic        sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fs_count = 0, err_count = 0, pv_count = 0;
    int pv_bad = 0, px_bad = 0;
    int fs_cyc = 0, err_cyc = 0, lock_rise_cyc = 0;
    int vs_drv_cyc = 0, hs_drv_cyc = 0;
    int cur_h = 0, cur_v = 0, h0 = 0, h1 = 0, v0 = 0, v1 = 0;
    logic [10:0] err_hmeas = '0;
    logic b0 = 1'b1, b1 = 1'b1, lk_q = 1'b0;

    vga_sync_decoder #(
        .H_TOTAL(H),
        .V_TOTAL(V),
        .LOCK_FRAMES(2)
    ) dut (
        .clk25(clk25),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .blank(blank),
        .px_x(px_x),
        .px_y(px_y),
        .px_valid(px_valid),
        .frame_start(frame_start),
        .locked(locked),
        .h_meas(h_meas),
        .v_meas(v_meas),
        .sync_err(sync_err)
    );

    always #20 clk25 = ~clk25;

    // Pin history: b1/h1/v1 is the pixel whose result shows two edges later.
    always @(posedge clk25) begin
        cyc++;
        b1 = b0;
        b0 = blank;
        h1 = h0;
        h0 = cur_h;
        v1 = v0;
        v0 = cur_v;
    end

    always @(negedge clk25) begin
        if (locked && !lk_q) lock_rise_cyc = cyc;
        if (frame_start) begin
            fs_count++;
            fs_cyc = cyc;
        end
        if (sync_err) begin
            err_count++;
            err_cyc   = cyc;
            err_hmeas = h_meas;
        end
        if (lk_q && locked) begin
            if (px_valid !== !b1) pv_bad++;
            if (px_valid === 1'b1) begin
                pv_count++;
                if (px_x !== 10'(h1) || px_y !== 10'(v1)) px_bad++;
            end
        end
        lk_q = locked;
    end

    task automatic drive_px(input int h, input int v, input bit coin);
        logic hs, vs, bl;
        bl = !(h < H_ACT && v < V_ACT);
        hs = !(h >= HS_BEG && h < HS_END);
        if (coin)
            vs = !((v == VS_LINE && h >= HS_BEG) || v == VS_LINE + 1 ||
                   (v == VS_LINE + 2 && h < HS_BEG));
        else
            vs = !(v == VS_LINE || v == VS_LINE + 1);
        if (hsync && !hs) hs_drv_cyc = cyc;
        if (vsync && !vs) vs_drv_cyc = cyc;
        hsync = hs;
        vsync = vs;
        blank = bl;
        cur_h = h;
        cur_v = v;
        @(posedge clk25);
        #1;
    endtask

    task automatic run_span(input int vs0, input int hs0, input int ve,
                            input int long_v, input bit coin);
        for (int v = vs0; v < ve; v++) begin
            int len;
            len = (v == long_v) ? H + 1 : H;
            for (int h = (v == vs0) ? hs0 : 0; h < len; h++)
                drive_px(h, v, coin);
        end
    endtask

    task automatic run_frame(input int long_v, input bit coin);
        pv_count = 0;
        run_span(0, 0, V, long_v, coin);
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        blank = 1'b1;
        repeat (3) begin
            @(posedge clk25);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        n_cmp++;
        if ({px_x, px_y, px_valid, frame_start, h_meas, v_meas, sync_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d v=%b fs=%b hm=%0d vm=%0d se=%b want all 0",
                     px_x, px_y, px_valid, frame_start, h_meas, v_meas, sync_err);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_locked: got %b want 0", locked);
        end
        @(posedge clk25);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lock();
        run_frame(-1, 0);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_f1: got %b want 0", locked);
        end
        run_frame(-1, 0);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_f2: got %b want 0", locked);
        end
        run_frame(-1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_f3: got %b want 1", locked);
        end
        n_cmp++;
        if (lock_rise_cyc - vs_drv_cyc != 2) begin
            n_bad++;
            $display("FAIL lock_latency: got %0d want 2", lock_rise_cyc - vs_drv_cyc);
        end
        n_cmp++;
        if (h_meas !== 11'(H)) begin
            n_bad++;
            $display("FAIL h_meas: got %0d want %0d", h_meas, H);
        end
        n_cmp++;
        if (v_meas !== 10'(V)) begin
            n_bad++;
            $display("FAIL v_meas: got %0d want %0d", v_meas, V);
        end
        n_cmp++;
        if (fs_count != 0) begin
            n_bad++;
            $display("FAIL fs_before_f4: got %0d want 0", fs_count);
        end
        run_frame(-1, 0);
        n_cmp++;
        if (fs_count != 1) begin
            n_bad++;
            $display("FAIL fs_f4: got %0d want 1", fs_count);
        end
        n_cmp++;
        if (fs_cyc - vs_drv_cyc != 2) begin
            n_bad++;
            $display("FAIL fs_latency: got %0d want 2", fs_cyc - vs_drv_cyc);
        end
    endtask

    task automatic test_active();
        run_frame(-1, 0);
        n_cmp++;
        if (pv_count != H_ACT * V_ACT) begin
            n_bad++;
            $display("FAIL pv_count: got %0d want %0d", pv_count, H_ACT * V_ACT);
        end
        n_cmp++;
        if (pv_bad != 0) begin
            n_bad++;
            $display("FAIL pv_follows_blank: got %0d bad want 0", pv_bad);
        end
        n_cmp++;
        if (px_bad != 0) begin
            n_bad++;
            $display("FAIL px_coords: got %0d bad want 0", px_bad);
        end
        n_cmp++;
        if (px_x !== 10'(H_ACT - 1) || px_y !== 10'(V_ACT - 1)) begin
            n_bad++;
            $display("FAIL px_hold: got %0d,%0d want %0d,%0d", px_x, px_y, H_ACT - 1, V_ACT - 1);
        end
        n_cmp++;
        if (fs_count != 2 || err_count != 0) begin
            n_bad++;
            $display("FAIL fs_err_f5: got fs=%0d err=%0d want 2,0", fs_count, err_count);
        end
    endtask

    task automatic test_long_line();
        int e0, f0;
        e0 = err_count;
        f0 = fs_count;
        run_frame(LONG_V, 0);
        n_cmp++;
        if (err_count - e0 != 1) begin
            n_bad++;
            $display("FAIL long_err: got %0d pulses want 1", err_count - e0);
        end
        n_cmp++;
        if (err_hmeas !== 11'(H + 1)) begin
            n_bad++;
            $display("FAIL long_hmeas: got %0d want %0d", err_hmeas, H + 1);
        end
        n_cmp++;
        if (locked !== 1'b0 || fs_count != f0) begin
            n_bad++;
            $display("FAIL long_unlock: got locked=%b fs=%0d want 0,%0d", locked, fs_count, f0);
        end
    endtask

    task automatic test_coincident();
        int e0, f0;
        e0 = err_count;
        run_frame(-1, 1);
        run_frame(-1, 1);
        n_cmp++;
        if (v_meas !== 10'(V)) begin
            n_bad++;
            $display("FAIL coin_vmeas: got %0d want %0d", v_meas, V);
        end
        run_frame(-1, 1);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL coin_lock: got %b want 1", locked);
        end
        f0 = fs_count;
        run_frame(-1, 1);
        n_cmp++;
        if (fs_count - f0 != 1 || err_count != e0) begin
            n_bad++;
            $display("FAIL coin_fs: got fs=%0d err=%0d want 1,0", fs_count - f0, err_count - e0);
        end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        repeat (3) run_frame(-1, 0);
        run_span(0, 0, 4, -1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_pre: got %b want 1", locked);
        end
        reset = 1'b1;
        drive_px(0, 4, 0);
        reset = 1'b0;
        @(negedge clk25);
        n_cmp++;
        if ({px_x, px_y, px_valid, frame_start, locked, h_meas, v_meas, sync_err} !== '0) begin
            n_bad++;
            $display("FAIL rmid_zero: got x=%0d y=%0d v=%b lk=%b hm=%0d vm=%0d want all 0",
                     px_x, px_y, px_valid, locked, h_meas, v_meas);
        end
        run_span(4, 1, V, -1, 0);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_e1: got %b want 0", locked);
        end
        run_frame(-1, 0);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_e2: got %b want 0", locked);
        end
        run_frame(-1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_e3: got %b want 1", locked);
        end
    endtask

    task automatic test_stuck();
        int e0;
        run_frame(-1, 0);
        e0 = err_count;
        hsync = 1'b1;
        vsync = 1'b1;
        blank = 1'b1;
        repeat (200) begin
            @(posedge clk25);
            #1;
        end
`ifdef VGA_SYNC_DEC_WATCHDOG_EN
        n_cmp++;
        if (err_count - e0 != 1) begin
            n_bad++;
            $display("FAIL wd_err: got %0d pulses want 1", err_count - e0);
        end
        n_cmp++;
        if (err_cyc - hs_drv_cyc != 2 * H + 2) begin
            n_bad++;
            $display("FAIL wd_time: got %0d want %0d", err_cyc - hs_drv_cyc, 2 * H + 2);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_unlock: got %b want 0", locked);
        end
`else
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL stuck_lock: got %b want 1", locked);
        end
        n_cmp++;
        if (err_count != e0) begin
            n_bad++;
            $display("FAIL stuck_err: got %0d pulses want 0", err_count - e0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_active();
        test_long_line();
        test_coincident();
        test_reset_mid();
        test_stuck();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
- REQ-001: Parameter H_TOTAL, default 800, sets the expected pixel clocks per line.
- REQ-002: Parameter V_TOTAL, default 525, sets the expected lines per frame.
- REQ-003: Parameter LOCK_FRAMES, default 2, sets the consecutive matching frames required for lock (range 1..15).
- REQ-004: clk25  input  1  pixel clock; the only clock in the block.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: hsync  input  1  horizontal sync, active low.
- REQ-007: vsync  input  1  vertical sync, active low.
- REQ-008: blank  input  1  high outside the active area.
- REQ-009: px_x  output  10  active-pixel column.
- REQ-010: px_y  output  10  active-line row.
- REQ-011: px_valid  output  1  px_x/px_y are valid for the current pixel.
- REQ-012: frame_start  output  1  one-cycle pulse at each frame boundary while locked.
- REQ-013: locked  output  1  timing matches the parameters.
- REQ-014: h_meas  output  11  last measured line length in clocks.
- REQ-015: v_meas  output  10  last measured frame length in lines.
- REQ-016: sync_err  output  1  one-cycle pulse when lock is lost.

Function
- REQ-017: hsync, vsync and blank SHALL be registered once (stage 1); all edge detection and counting SHALL use the stage-1 values.
- REQ-018: An edge event SHALL be a 1->0 transition of a stage-1 sync signal, seen as previous 1 and current 0.
- REQ-019: The line counter (11 bits) SHALL increment every clock and saturate at 2047. On each hsync edge it SHALL load h_meas with its count plus 1, then restart at 0.
- REQ-020: The frame line counter (10 bits) SHALL increment on each hsync edge and saturate at 1023. On each vsync edge it SHALL load v_meas with its count, including any hsync edge in the same cycle, then restart at 0.
- REQ-021: The state machine SHALL have three states: SEARCH (entered at reset), ALIGN and LOCKED.
- REQ-022: SEARCH SHALL move to ALIGN on a vsync edge, clearing good_cnt.
- REQ-023: In ALIGN, each vsync edge SHALL compare h_meas with H_TOTAL and the new v_meas with V_TOTAL. On a match, good_cnt increments; when good_cnt reaches LOCK_FRAMES the state SHALL become LOCKED. On a mismatch the state SHALL return to SEARCH with no sync_err.
- REQ-024: In LOCKED, a vsync edge with a mismatch SHALL pulse sync_err and move to SEARCH. A vsync edge with a match SHALL pulse frame_start.
- REQ-025: locked SHALL be high exactly when the state is LOCKED.
- REQ-026: px_x SHALL be 0 on the first clock of stage-1 blank being low after it was high, then increment by 1 each active clock, saturating at 1023.
- REQ-027: px_y SHALL be 0 on the first active line after a vsync edge, then increment by 1 at each later active-line start, saturating at 1023.
- REQ-028: px_valid SHALL equal locked AND (stage-1 blank low); all outputs are registered, giving 2 clk25 of latency from the input pins.
- REQ-029: When blank is high, px_x and px_y SHALL hold their last values.
- REQ-030: If vsync and hsync edges occur in the same cycle, the hsync edge SHALL first count into v_meas (REQ-020), then the frame closes.

Reset
- REQ-031: While reset is high, the block SHALL clear every output, counter, good_cnt and the stage-1 registers to 0, with stage-1 sync values set to 1 (idle). The state SHALL be SEARCH.
- REQ-032: Reset asserted mid-frame SHALL take effect on the next clk25 edge; lock SHALL then need a full reacquisition.

Configuration
- REQ-033: With VGA_SYNC_DEC_WATCHDOG_EN defined, the block SHALL include a 12-bit watchdog that counts clocks since the last hsync edge. On reaching 2*H_TOTAL while in ALIGN or LOCKED, it SHALL force SEARCH, pulse sync_err (in LOCKED only) and restart the count.
- REQ-034: Without VGA_SYNC_DEC_WATCHDOG_EN, no watchdog logic SHALL exist; stuck sync inputs leave the state unchanged.

Verification
- REQ-035: Drive standard 800x525 timing for 3 frames -> locked rises at the 3rd vsync edge; h_meas=800, v_meas=525; frame_start first pulses at the 4th vsync edge.
- REQ-036: While locked, check active area -> px_x runs 0..639 and px_y runs 0..479; px_valid is high for exactly 640x480 clocks per frame and follows blank by 2 cycles.
- REQ-037: After lock, lengthen one line to 801 clocks -> at the next vsync edge h_meas=801, sync_err pulses once and locked falls.
- REQ-038: Place a vsync edge coincident with an hsync edge every frame -> v_meas=525 and lock is achieved.
- REQ-039: Assert reset for 1 cycle mid-frame while locked -> all outputs are 0 the next cycle, and locked recovers only after LOCK_FRAMES+1 vsync edges.
- REQ-040: With VGA_SYNC_DEC_WATCHDOG_EN, hold hsync high after lock -> sync_err pulses 1600 clocks after the last hsync edge and locked falls. Without the macro -> locked stays high.
